uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter among N byte-producing requesters, such as the CPU and a hardware echo/debug path. It sits between the requesters and the transmitter's `send_req`/`data`/`busy` port. Each granted byte is launched with a one-cycle `tx_req`, and the arbiter tracks `tx_busy` through the whole frame before it grants again. Arbitration is round-robin. An optional lock feature lets one requester send a multi-byte sequence without interleaving.

---
 rtl/uart_tx_arbiter_if.sv | 64 ++++++
 rtl/uart_tx_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
//
// Bundles the requester side and the transmitter side of the UART TX
// arbiter into one interface.
//
// Parameter:
//   N         number of byte requesters (2..8); must match the arbiter's N
//
// Signals:
//   req       [N]      per-requester byte valid, held until ack
//   data      [8*N]    byte for requester i in data[8*i+7:8*i]
//   lock      [N]      per-requester lock request (used only when the
//                      arbiter is built with UART_TX_ARB_LOCK_EN)
//   ack       [N]      one-cycle capture pulse back to the requester
//   tx_req             one-cycle launch pulse to the transmitter
//   tx_data   [8]      captured byte, stable for the whole frame
//   tx_busy            transmitter busy
//   grant_id  [IDW]    index of the last granted requester
//   drop               one-cycle pulse when a launch times out
//
// Modports:
//   master    arbiter view (drives ack/tx_req/tx_data/grant_id/drop)
//   slave     environment view (requesters plus transmitter)
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int N = 2
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req;
  logic [8*N-1:0] data;
  logic [N-1:0]   lock;
  logic [N-1:0]   ack;
  logic           tx_req;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic [IDW-1:0] grant_id;
  logic           drop;

  modport master (
    input  req,
    input  data,
    input  lock,
    input  tx_busy,
    output ack,
    output tx_req,
    output tx_data,
    output grant_id,
    output drop
  );

  modport slave (
    output req,
    output data,
    output lock,
    output tx_busy,
    input  ack,
    input  tx_req,
    input  tx_data,
    input  grant_id,
    input  drop
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter among N byte producers. A granted byte is
// captured into tx_data, launched with a single-cycle tx_req, and the
// arbiter then follows tx_busy through the whole frame before it will
// grant again. Arbitration is round-robin starting from a rotating pointer.
//
// Optional feature (compile-time macro UART_TX_ARB_LOCK_EN):
//   a requester granted while its lock bit is high becomes the owner and
//   stays the only eligible requester until it drops lock in an IDLE
//   cycle (or a launch times out). Without the macro the lock inputs are
//   ignored and no owner state exists.
//
// Parameters:
//   N         number of requesters, 2..8
//   TIMEOUT   cycles to wait for tx_busy to rise after tx_req before the
//             launch is abandoned and drop is pulsed
//
// Ports:
//   clk       system clock
//   reset     asynchronous, active-low reset
//   bus       uart_tx_arbiter_if.master (req/data/lock/ack, tx_req/tx_data/
//             tx_busy, grant_id, drop)
//
// All outputs come straight from flops; nothing in req reaches ack
// combinationally.
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int N       = 2,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_arbiter_if.master bus
);

  localparam int IDW  = (N > 1) ? $clog2(N) : 1;
  localparam int CNTW = $clog2(TIMEOUT + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_RISE = 2'd2,
    WAIT_FALL = 2'd3
  } state_t;

  // _p0: next-state values computed this cycle; _p1: registered state.
  state_t          state_p0, state_p1;
  logic [IDW-1:0]  ptr_p0, ptr_p1;
  logic [CNTW-1:0] cnt_p0, cnt_p1;
  logic [N-1:0]    ack_p0, ack_p1;
  logic            tx_req_p0, tx_req_p1;
  logic [7:0]      tx_data_p0, tx_data_p1;
  logic [IDW-1:0]  gid_p0, gid_p1;
  logic            drop_p0, drop_p1;

  logic [N-1:0]    elig;
  logic            win_vld;
  logic [IDW-1:0]  win_id;
  logic [7:0]      win_data;

`ifdef UART_TX_ARB_LOCK_EN
  logic           own_vld_p0, own_vld_p1;
  logic [IDW-1:0] own_id_p0, own_id_p1;
  logic           lock_held;

  // While the owner keeps lock high it is the only eligible requester,
  // even when its req is low; everyone else simply waits.
  always_comb begin
    lock_held = own_vld_p1 && bus.lock[own_id_p1];
    if (lock_held) begin
      elig = bus.req & (N'(1) << own_id_p1);
    end else begin
      elig = bus.req;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^bus.lock;
  assign elig        = bus.req;
`endif

  // ---- stage p0: round-robin pick, scanning upward from ptr modulo N ----
  always_comb begin
    int sum;
    logic [IDW-1:0] idx;
    sum      = 0;
    idx      = '0;
    win_vld  = 1'b0;
    win_id   = '0;
    win_data = 8'h00;
    for (int k = 0; k < N; k++) begin
      sum = int'(ptr_p1) + k;
      if (sum >= N) begin
        sum = sum - N;
      end
      idx = IDW'(sum);
      if (!win_vld && elig[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (win_id == IDW'(i)) begin
        win_data = bus.data[8*i +: 8];
      end
    end
  end

  // ---- stage p0: FSM next state and next output values ----
  always_comb begin
    state_p0   = state_p1;
    ptr_p0     = ptr_p1;
    cnt_p0     = cnt_p1;
    ack_p0     = '0;
    tx_req_p0  = 1'b0;
    tx_data_p0 = tx_data_p1;
    gid_p0     = gid_p1;
    drop_p0    = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
    own_vld_p0 = own_vld_p1;
    own_id_p0  = own_id_p1;
`endif

    case (state_p1)
      IDLE: begin
`ifdef UART_TX_ARB_LOCK_EN
        // Ownership ends in the first IDLE cycle where the owner's lock
        // is low; the pick below already ignores the stale owner.
        if (own_vld_p1 && !bus.lock[own_id_p1]) begin
          own_vld_p0 = 1'b0;
        end
`endif
        // A busy transmitter in IDLE may be finishing a frame launched by
        // someone else (or one cut short by reset): never grant over it.
        if (!bus.tx_busy && win_vld) begin
          state_p0   = LAUNCH;
          ack_p0     = N'(1) << win_id;
          tx_req_p0  = 1'b1;
          tx_data_p0 = win_data;
          gid_p0     = win_id;
          if (int'(win_id) == N - 1) begin
            ptr_p0 = '0;
          end else begin
            ptr_p0 = win_id + 1'b1;
          end
`ifdef UART_TX_ARB_LOCK_EN
          if (bus.lock[win_id]) begin
            own_vld_p0 = 1'b1;
            own_id_p0  = win_id;
          end
`endif
        end
      end

      LAUNCH: begin
        state_p0 = WAIT_RISE;
        cnt_p0   = '0;
      end

      WAIT_RISE: begin
        if (bus.tx_busy) begin
          state_p0 = WAIT_FALL;
        end else if (cnt_p1 == CNT_LAST) begin
          // TIMEOUT cycles spent here without busy: the byte is lost.
          state_p0 = IDLE;
          drop_p0  = 1'b1;
`ifdef UART_TX_ARB_LOCK_EN
          own_vld_p0 = 1'b0;
`endif
        end else begin
          cnt_p0 = cnt_p1 + 1'b1;
        end
      end

      WAIT_FALL: begin
        if (!bus.tx_busy) begin
          state_p0 = IDLE;
        end
      end

      default: begin
        state_p0 = IDLE;
      end
    endcase
  end

  // ---- stage p1: state and output registers ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_p1   <= IDLE;
      ptr_p1     <= '0;
      cnt_p1     <= '0;
      ack_p1     <= '0;
      tx_req_p1  <= 1'b0;
      tx_data_p1 <= 8'h00;
      gid_p1     <= '0;
      drop_p1    <= 1'b0;
    end else begin
      state_p1   <= state_p0;
      ptr_p1     <= ptr_p0;
      cnt_p1     <= cnt_p0;
      ack_p1     <= ack_p0;
      tx_req_p1  <= tx_req_p0;
      tx_data_p1 <= tx_data_p0;
      gid_p1     <= gid_p0;
      drop_p1    <= drop_p0;
    end
  end

`ifdef UART_TX_ARB_LOCK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      own_vld_p1 <= 1'b0;
      own_id_p1  <= '0;
    end else begin
      own_vld_p1 <= own_vld_p0;
      own_id_p1  <= own_id_p0;
    end
  end
`endif

  assign bus.ack      = ack_p1;
  assign bus.tx_req   = tx_req_p1;
  assign bus.tx_data  = tx_data_p1;
  assign bus.grant_id = gid_p1;
  assign bus.drop     = drop_p1;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Self-checking bench for uart_tx_arbiter with N=2, TIMEOUT=16. Contains a
// simple transmitter model (busy for a fixed or random number of cycles
// after each tx_req, or never busy), a directed vector table, hand-written
// multi-cycle sequences, and a queue-based requester/scoreboard engine for
// randomized traffic and the lock sequence.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;
  localparam int N       = 2;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N(N)) bus();

  uart_tx_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // transmitter model state
  bit force_busy = 1'b0;
  bit never_busy = 1'b0;
  bit rand_len   = 1'b0;
  int busy_len   = 10;
  int busy_left  = 0;
  bit nb         = 1'b0;

  // requester queues and sent-byte log
  logic [7:0] rq0[$];
  logic [7:0] rq1[$];
  logic [7:0] sent[$];
  int         ptr_m;

  typedef struct {
    logic [1:0] req;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] ack;
    logic [7:0] data;
    logic       gid;
  } vec_t;

  vec_t vt[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic xmit_step();
    if (bus.tx_req && !never_busy) begin
      nb        = 1'b1;
      busy_left = (rand_len ? int'($urandom_range(2, 12)) : busy_len) - 1;
    end else if (busy_left > 0) begin
      busy_left--;
    end else begin
      nb = 1'b0;
    end
    bus.tx_busy = force_busy | nb;
  endtask

  task automatic cyc();
    @(negedge clk);
    xmit_step();
  endtask

  task automatic wait_frame_end(input string name);
    bit seen;
    bit done;
    seen = bus.tx_busy;
    done = 1'b0;
    for (int k = 0; k < 80; k++) begin
      cyc();
      if (bus.tx_busy) begin
        seen = 1'b1;
      end else if (seen) begin
        done = 1'b1;
        break;
      end
    end
    check($sformatf("%s frame end", name), done, 1);
    cyc();
  endtask

  task automatic do_reset();
    for (int k = 0; k < 40 && bus.tx_busy; k++) cyc();
    reset = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
  endtask

  function automatic int rr_pick(input logic [1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic drive_reqs(input bit use_lock, input bit withdraw);
    logic [1:0] r;
    logic [1:0] l;
    logic [7:0] d0;
    logic [7:0] d1;
    d0   = (rq0.size() != 0) ? rq0[0] : 8'($urandom);
    d1   = (rq1.size() != 0) ? rq1[0] : 8'($urandom);
    r[0] = (rq0.size() != 0);
    r[1] = (rq1.size() != 0);
    l    = use_lock ? r : 2'b00;
    if (withdraw) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) r[i] = 1'b0;
      end
    end
    bus.req  = r;
    bus.lock = l;
    bus.data = {d1, d0};
  endtask

  // Requesters pop their queue on ack; every grant is scored against the
  // head byte of the acked requester and, optionally, the round-robin rule.
  task automatic run_engine(input bit chk_rr, input bit use_lock, input bit withdraw,
                            input int max_cyc, input string tag);
    logic [1:0] prev_req;
    bit         prev_busy;
    int         idle_cnt;
    bit         done;
    int         w;
    drive_reqs(use_lock, withdraw);
    prev_req  = bus.req;
    prev_busy = bus.tx_busy;
    idle_cnt  = 0;
    done      = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      cyc();
      check($sformatf("%s tx_req with ack", tag), bus.tx_req, (bus.ack != 2'b00));
      if (bus.ack != 2'b00) begin
        w = bus.ack[1] ? 1 : 0;
        check($sformatf("%s ack onehot", tag), $onehot(bus.ack), 1);
        check($sformatf("%s grant_id", tag), bus.grant_id, w);
        check($sformatf("%s grant while busy", tag), prev_busy, 0);
        check($sformatf("%s ack without req", tag), prev_req[w], 1);
        if (chk_rr) check($sformatf("%s rr winner", tag), w, rr_pick(prev_req, ptr_m));
        if (w == 0 && rq0.size() != 0) begin
          check($sformatf("%s data r0", tag), bus.tx_data, rq0[0]);
          sent.push_back(rq0.pop_front());
        end else if (w == 1 && rq1.size() != 0) begin
          check($sformatf("%s data r1", tag), bus.tx_data, rq1[0]);
          sent.push_back(rq1.pop_front());
        end
        ptr_m = (w + 1) % N;
      end
      drive_reqs(use_lock, withdraw);
      prev_req  = bus.req;
      prev_busy = bus.tx_busy;
      if (rq0.size() == 0 && rq1.size() == 0 && !bus.tx_busy) idle_cnt++;
      else idle_cnt = 0;
      if (idle_cnt >= 3) begin
        done = 1'b1;
        break;
      end
    end
    check($sformatf("%s drained", tag), done, 1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int cnt;
    int fall_at;
    bit pb;
    bit bad;
    int dcyc;
    int total;
    bit got;
    logic [7:0] exp_lock[4];

    vt[0] = '{2'b01, 8'h41, 8'h00, 2'b01, 8'h41, 1'b0};
    vt[1] = '{2'b11, 8'h10, 8'h20, 2'b10, 8'h20, 1'b1};
    vt[2] = '{2'b11, 8'h10, 8'h20, 2'b01, 8'h10, 1'b0};
    vt[3] = '{2'b11, 8'h10, 8'h20, 2'b10, 8'h20, 1'b1};
    vt[4] = '{2'b10, 8'h00, 8'h5A, 2'b10, 8'h5A, 1'b1};
    vt[5] = '{2'b11, 8'hC3, 8'h3C, 2'b01, 8'hC3, 1'b0};
    vt[6] = '{2'b01, 8'hFF, 8'h11, 2'b01, 8'hFF, 1'b0};
    vt[7] = '{2'b10, 8'h22, 8'h81, 2'b10, 8'h81, 1'b1};

    reset       = 1'b0;
    bus.req     = '0;
    bus.data    = '0;
    bus.lock    = '0;
    bus.tx_busy = 1'b0;
    cyc();
    cyc();
    check("reset ack", bus.ack, 0);
    check("reset tx_req", bus.tx_req, 0);
    check("reset tx_data", bus.tx_data, 0);
    check("reset grant_id", bus.grant_id, 0);
    check("reset drop", bus.drop, 0);
    reset = 1'b1;
    cyc();

    // directed vector table, one frame per entry
    for (int v = 0; v < 8; v++) begin
      bus.req  = vt[v].req;
      bus.data = {vt[v].d1, vt[v].d0};
      cyc();
      check($sformatf("vec%0d ack", v), bus.ack, vt[v].ack);
      check($sformatf("vec%0d tx_req", v), bus.tx_req, 1);
      check($sformatf("vec%0d tx_data", v), bus.tx_data, vt[v].data);
      check($sformatf("vec%0d grant_id", v), bus.grant_id, vt[v].gid);
      bus.req = '0;
      wait_frame_end($sformatf("vec%0d", v));
      check($sformatf("vec%0d tx_data hold", v), bus.tx_data, vt[v].data);
    end

    // contention: both held, alternate grants, 2-cycle gap after busy falls
    bus.req  = 2'b11;
    bus.data = {8'h20, 8'h10};
    g        = 0;
    cnt      = 0;
    fall_at  = -100;
    pb       = bus.tx_busy;
    for (int k = 0; k < 200 && g < 4; k++) begin
      cyc();
      cnt++;
      if (pb && !bus.tx_busy) fall_at = cnt;
      pb = bus.tx_busy;
      if (bus.ack != 2'b00) begin
        check($sformatf("cont%0d grant_id", g), bus.grant_id, g % 2);
        check($sformatf("cont%0d tx_data", g), bus.tx_data, (g % 2) ? 8'h20 : 8'h10);
        if (g > 0) check($sformatf("cont%0d gap", g), cnt - fall_at, 2);
        g++;
        if (g == 4) bus.req = '0;
      end
    end
    check("cont grants", g, 4);
    wait_frame_end("cont");

    // busy already high in IDLE: hold off until it falls
    force_busy  = 1'b1;
    bus.tx_busy = 1'b1;
    bus.req     = 2'b10;
    bus.data    = {8'h77, 8'h00};
    bad         = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (bus.ack != 2'b00 || bus.tx_req) bad = 1'b1;
    end
    check("busy idle no grant", bad, 0);
    force_busy  = 1'b0;
    bus.tx_busy = nb;
    cyc();
    check("busy idle ack", bus.ack, 2'b10);
    check("busy idle tx_data", bus.tx_data, 8'h77);
    bus.req = '0;
    wait_frame_end("busy idle");

    // timeout: transmitter never raises busy
    never_busy = 1'b1;
    bus.req    = 2'b01;
    bus.data   = {8'h00, 8'h99};
    cyc();
    check("timeout ack", bus.ack, 2'b01);
    check("timeout tx_req", bus.tx_req, 1);
    bus.req = '0;
    dcyc    = 0;
    bad     = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      if (bus.ack != 2'b00 || bus.tx_req) bad = 1'b1;
      if (bus.drop) begin
        dcyc = k;
        break;
      end
    end
    // tx_req cycle + 16 WAIT_RISE cycles
    check("timeout drop latency", dcyc, 17);
    check("timeout no regrant", bad, 0);
    cyc();
    check("timeout drop width", bus.drop, 0);
    check("timeout tx_data hold", bus.tx_data, 8'h99);
    never_busy = 1'b0;
    bus.req    = 2'b01;
    bus.data   = {8'h00, 8'h55};
    cyc();
    check("after timeout ack", bus.ack, 2'b01);
    check("after timeout tx_data", bus.tx_data, 8'h55);
    bus.req = '0;
    wait_frame_end("after timeout");

    // reset during WAIT_FALL; pointer was left at 1 by the last grant
    bus.req  = 2'b01;
    bus.data = {8'h00, 8'hE7};
    cyc();
    check("pre-reset ack", bus.ack, 2'b01);
    bus.req = '0;
    cyc();
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    check("midrst ack", bus.ack, 0);
    check("midrst tx_req", bus.tx_req, 0);
    check("midrst tx_data", bus.tx_data, 0);
    check("midrst grant_id", bus.grant_id, 0);
    check("midrst drop", bus.drop, 0);
    cyc();
    cyc();
    reset    = 1'b1;
    bus.req  = 2'b11;
    bus.data = {8'h32, 8'h31};
    got      = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (bus.ack != 2'b00) begin
        got = 1'b1;
        break;
      end
    end
    check("post-reset grant seen", got, 1);
    check("post-reset ack", bus.ack, 2'b01);
    check("post-reset tx_data", bus.tx_data, 8'h31);
    bus.req = '0;
    wait_frame_end("post-reset");

    // lock sequence
    do_reset();
    ptr_m = 0;
    sent.delete();
    rq0 = '{8'hA0, 8'hA1, 8'hA2};
    rq1 = '{8'hB1};
    run_engine(1'b0, 1'b1, 1'b0, 400, "lock");
`ifdef UART_TX_ARB_LOCK_EN
    exp_lock = '{8'hA0, 8'hA1, 8'hA2, 8'hB1};
`else
    exp_lock = '{8'hA0, 8'hB1, 8'hA1, 8'hA2};
`endif
    check("lock count", sent.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < sent.size()) check($sformatf("lock byte%0d", i), sent[i], exp_lock[i]);
    end

    // randomized traffic with withdrawals and random frame lengths
    do_reset();
    ptr_m    = 0;
    rand_len = 1'b1;
    sent.delete();
    rq0.delete();
    rq1.delete();
    for (int i = 0; i < 12 + int'($urandom_range(0, 7)); i++) rq0.push_back(8'($urandom));
    for (int i = 0; i < 12 + int'($urandom_range(0, 7)); i++) rq1.push_back(8'($urandom));
    total = rq0.size() + rq1.size();
    run_engine(1'b1, 1'b0, 1'b1, 4000, "rand");
    check("rand byte count", sent.size(), total);
    rand_len = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
